// File: rtl/ir_transmitter_pkg.sv
// Shared protocol constants and state encoding for the rover IR command link.
// The matching receiver imports the same package so both ends agree on framing.
package ir_transmitter_pkg;

  localparam int DATA_BITS       = 12;
  localparam int START_UNITS     = 4;
  localparam int ZERO_MARK_UNITS = 1;
  localparam int ONE_MARK_UNITS  = 2;
  localparam int SPACE_UNITS     = 1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_MARK = 3'd1,
    BIT_SPACE  = 3'd2,
    BIT_MARK   = 3'd3,
    GAP        = 3'd4
  } ir_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic is_mark(input ir_state_t s);
    return (s == START_MARK) || (s == BIT_MARK);
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Free-running carrier counter; a synchronous restart aligns the carrier phase
// so that every mark begins in the high half of a carrier period.
module ir_carrier_gen
  import ir_transmitter_pkg::*;
#(
  parameter int CARRIER_PERIOD = 625
) (
  input  logic clock,
  input  logic reset_n,
  input  logic restart,
  output logic carrier
);

  localparam int CW = cnt_width(CARRIER_PERIOD);

  logic [CW-1:0] carrier_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      carrier_cnt <= '0;
    end else if (restart || (carrier_cnt == CW'(CARRIER_PERIOD - 1))) begin
      carrier_cnt <= '0;
    end else begin
      carrier_cnt <= carrier_cnt + CW'(1);
    end
  end

  assign carrier = (carrier_cnt < CW'(CARRIER_PERIOD / 2));

endmodule

// File: rtl/ir_transmitter.sv
// Serialises a move command into a pulse-width-coded IR frame: start mark,
// per-bit space + mark (long mark = 1, LSB first), then a silent gap.
module ir_transmitter
  import ir_transmitter_pkg::*;
#(
  parameter int UNIT_CYCLES    = 15000,
  parameter int CARRIER_PERIOD = 625,
  parameter int GAP_UNITS      = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] command,
  output logic                 busy,
  output logic                 done,
  output logic                 envelope,
  output logic                 ir_out,
  output ir_state_t            state
);

  // Handshake: start is a request sampled every clock; it is accepted only when
  // the FSM is IDLE or on the final GAP clock, and busy (registered) then stays
  // high until the frame's gap ends. Requests while busy are dropped.

  localparam int UW = cnt_width(UNIT_CYCLES);
  localparam int MAX_UNITS = (GAP_UNITS > START_UNITS) ?
                             ((GAP_UNITS > ONE_MARK_UNITS) ? GAP_UNITS : ONE_MARK_UNITS) :
                             ((START_UNITS > ONE_MARK_UNITS) ? START_UNITS : ONE_MARK_UNITS);
  localparam int SW = cnt_width(MAX_UNITS);
  localparam int BW = cnt_width(DATA_BITS);

  ir_state_t            state_d;
  logic [UW-1:0]        unit_cnt, unit_cnt_d;
  logic [SW-1:0]        units, units_d, units_last;
  logic [BW-1:0]        bit_idx, bit_idx_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic                 unit_tick, state_exit, accept;
  logic                 busy_d, done_d, envelope_d, restart, carrier;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      unit_cnt <= '0;
      units    <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      envelope <= 1'b0;
    end else begin
      state    <= state_d;
      unit_cnt <= unit_cnt_d;
      units    <= units_d;
      bit_idx  <= bit_idx_d;
      shreg    <= shreg_d;
      busy     <= busy_d;
      done     <= done_d;
      envelope <= envelope_d;
    end
  end

  always_comb begin
    state_d    = state;
    unit_cnt_d = unit_cnt;
    units_d    = units;
    bit_idx_d  = bit_idx;
    shreg_d    = shreg;
    unit_tick  = (unit_cnt == UW'(UNIT_CYCLES - 1));

    case (state)
      START_MARK: units_last = SW'(START_UNITS - 1);
      BIT_SPACE:  units_last = SW'(SPACE_UNITS - 1);
      BIT_MARK:   units_last = shreg[0] ? SW'(ONE_MARK_UNITS - 1) : SW'(ZERO_MARK_UNITS - 1);
      GAP:        units_last = SW'(GAP_UNITS - 1);
      default:    units_last = '0;
    endcase

    state_exit = (state != IDLE) && unit_tick && (units == units_last);

    if (state != IDLE) begin
      unit_cnt_d = unit_tick ? '0 : unit_cnt + UW'(1);
      if (unit_tick) units_d = state_exit ? '0 : units + SW'(1);
    end

    if (state_exit) begin
      case (state)
        START_MARK: state_d = BIT_SPACE;
        BIT_SPACE:  state_d = BIT_MARK;
        BIT_MARK: begin
          shreg_d = shreg >> 1;
          if (bit_idx == BW'(DATA_BITS - 1)) begin
            state_d = GAP;
          end else begin
            bit_idx_d = bit_idx + BW'(1);
            state_d   = BIT_SPACE;
          end
        end
        GAP:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // The final GAP clock doubles as an idle slot so frames can run back to back.
    accept = start && ((state == IDLE) || ((state == GAP) && state_exit));
    if (accept) begin
      state_d    = START_MARK;
      shreg_d    = command;
      unit_cnt_d = '0;
      units_d    = '0;
      bit_idx_d  = '0;
    end

    busy_d     = (state_d != IDLE);
    envelope_d = is_mark(state_d);
    done_d     = (state_d == GAP) && (unit_cnt_d == UW'(UNIT_CYCLES - 1)) &&
                 (units_d == SW'(GAP_UNITS - 1));
    restart    = is_mark(state_d) && (state_d != state);
  end

  ir_carrier_gen #(
    .CARRIER_PERIOD(CARRIER_PERIOD)
  ) u_carrier (
    .clock   (clock),
    .reset_n (reset_n),
    .restart (restart),
    .carrier (carrier)
  );

  assign ir_out = envelope & carrier;

endmodule

// File: tb/tb_ir_transmitter.sv
// Bench for ir_transmitter: drivers push accepted commands into exp_q, a monitor
// captures each frame up to done and checks it against a waveform built from the framing rules.
module tb_ir_transmitter;
  import ir_transmitter_pkg::*;

  localparam int U  = 10;
  localparam int P  = 4;
  localparam int G  = 2;
  localparam int NB = DATA_BITS;
  localparam int MAX_FRAME = U * (START_UNITS + 3 * NB + G);

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic [11:0] command = '0;
  logic        busy, done, envelope, ir_out;
  ir_state_t   state;

  int vectors = 0;
  int miscompares = 0;
  logic [11:0] exp_q[$];
  bit cap_env[$];
  bit cap_ir[$];

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  ir_transmitter #(
    .UNIT_CYCLES(U),
    .CARRIER_PERIOD(P),
    .GAP_UNITS(G)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .command  (command),
    .busy     (busy),
    .done     (done),
    .envelope (envelope),
    .ir_out   (ir_out),
    .state    (state)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  task automatic check_frame();
    logic [11:0] cmd;
    logic [11:0] decoded;
    bit e_env[$];
    bit e_ir[$];
    int marks[$];
    int run, env_err, ir_err, exp_len;
    if (exp_q.size() == 0) begin
      check("unexpected_frame", 1, 0);
      return;
    end
    cmd = exp_q.pop_front();
    for (int k = 0; k < U * START_UNITS; k++) begin
      e_env.push_back(1'b1); e_ir.push_back((k % P) < P / 2);
    end
    for (int b = 0; b < NB; b++) begin
      for (int k = 0; k < U; k++) begin e_env.push_back(1'b0); e_ir.push_back(1'b0); end
      for (int k = 0; k < U * (cmd[b] ? 2 : 1); k++) begin
        e_env.push_back(1'b1); e_ir.push_back((k % P) < P / 2);
      end
    end
    for (int k = 0; k < U * G; k++) begin e_env.push_back(1'b0); e_ir.push_back(1'b0); end
    exp_len = U * (START_UNITS + 2 * NB + $countones(cmd) + G);
    check($sformatf("frame_len_%03h", cmd), cap_env.size(), exp_len);
    env_err = 0;
    ir_err = 0;
    for (int i = 0; i < cap_env.size() && i < e_env.size(); i++) begin
      if (cap_env[i] != e_env[i]) env_err++;
      if (cap_ir[i] != e_ir[i]) ir_err++;
    end
    check($sformatf("envelope_errs_%03h", cmd), env_err, 0);
    check($sformatf("ir_out_errs_%03h", cmd), ir_err, 0);
    run = 0;
    for (int i = 0; i < cap_env.size(); i++) begin
      if (cap_env[i]) run++;
      else if (run > 0) begin marks.push_back(run); run = 0; end
    end
    if (run > 0) marks.push_back(run);
    check($sformatf("mark_count_%03h", cmd), marks.size(), NB + 1);
    decoded = '0;
    if (marks.size() == NB + 1)
      for (int b = 0; b < NB; b++) decoded[b] = (marks[b + 1] > (3 * U) / 2);
    check($sformatf("decode_%03h", cmd), int'(decoded), int'(cmd));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (!reset_n) begin
      cap_env.delete();
      cap_ir.delete();
    end else begin
      if (done && !busy) check("done_without_busy", 1, 0);
      if (!busy && cap_env.size() != 0) begin
        check("busy_dropped_without_done", 1, 0);
        cap_env.delete(); cap_ir.delete();
      end
      if (busy) begin
        cap_env.push_back(envelope);
        cap_ir.push_back(ir_out);
      end
      if (done) begin
        check_frame();
        cap_env.delete(); cap_ir.delete();
      end else if (cap_env.size() > MAX_FRAME) begin
        check("frame_overrun", cap_env.size(), MAX_FRAME);
        cap_env.delete(); cap_ir.delete();
      end
    end
  end

  // ---------------- drivers (called at a falling edge) ----------------
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 1000) begin @(negedge clock); n++; end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  task automatic issue(input logic [11:0] cmd);
    start = 1'b1;
    command = cmd;
    exp_q.push_back(cmd);
    @(negedge clock);
    start = 1'b0;
    command = 12'($urandom);
    check("accept_busy", busy, 1);
    check("accept_envelope", envelope, 1);
    check("accept_ir_out", ir_out, 1);
  endtask

  task automatic send(input logic [11:0] cmd);
    wait_idle();
    issue(cmd);
  endtask

  task automatic send_on_done(input logic [11:0] cmd);
    int n = 0;
    while (!done && n < 1000) begin @(negedge clock); n++; end
    if (!done) check("done_timeout", 1, 0);
    issue(cmd);
  endtask

  task automatic poke_ignored(input logic [11:0] cmd);
    start = 1'b1;
    command = cmd;
    @(negedge clock);
    start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seen;
    logic [11:0] cmd;
    start = 1'b1;
    command = 12'h3C3;
    repeat (5) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_envelope", envelope, 0);
    check("rst_ir_out", ir_out, 0);
    check("rst_state", int'(state), int'(IDLE));
    reset_n = 1'b1;
    start = 1'b0;
    seen = 0;
    repeat (20) begin @(negedge clock); if (busy) seen++; end
    check("no_frame_after_reset", seen, 0);

    send(12'h000);
    send(12'hFFF);
    send(12'hA5A);

    send(12'h456);
    repeat ($urandom_range(50, 200)) @(negedge clock);
    poke_ignored(12'h123);
    send_on_done(12'h3E7);

    send(12'h001);
    repeat (55) @(negedge clock);
    check("pre_abort_state", int'(state), int'(BIT_MARK));
    check("pre_abort_envelope", envelope, 1);
    void'(exp_q.pop_back());
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_envelope", envelope, 0);
    check("async_rst_ir_out", ir_out, 0);
    check("async_rst_done", done, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    send(12'h001);

    for (int i = 0; i < 8; i++) begin
      cmd = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 2) == 0 && busy) send_on_done(cmd);
      else send(cmd);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(5, 150)) @(negedge clock);
        if (busy) poke_ignored(12'($urandom));
      end
    end

    wait_idle();
    repeat (5) @(negedge clock);
    check("pending_frames", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
